mio_bus_arb: RTL and testbench

Parametrised memory-mapped I/O bus controller and next-generation CPU-side interconnect.
- Decodes CPU accesses to N_SLAVES address windows, each defined by a base/mask pair.
- Runs a request/ready handshake with each slave, so a slave can insert any number of wait states.
- Generates the CPU wait and acknowledge signals and the registered read-data return path.
- Times out accesses to unresponsive slaves and flags accesses that hit no window as a bus error.

---
 rtl/mio_pkg.sv | 21 ++
 rtl/mio_addr_decode.sv | 27 ++
 rtl/mio_bus_arb.sv | 138 +++++++++++++
 tb/tb_mio_bus_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the memory-mapped I/O bus controller:
// FSM encoding, default slave windows and the bus-error read value.
package mio_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] VRAM_BASE = 32'h000C_0000;
  localparam logic [31:0] VRAM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] SEG7_BASE = 32'hFFFF_FE00;
  localparam logic [31:0] SEG7_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] LED_BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] LED_MASK  = 32'hFFFF_FF00;

  localparam logic [31:0] BUS_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational base/mask window decoder with lowest-index priority.
// Shared between the CPU-side controller and other bus ports.
module mio_addr_decode #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [31:0]      addr,
  input  logic [N*32-1:0]  base,
  input  logic [N*32-1:0]  mask,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: defaults first so every path assigns hit/idx and no latch is inferred.
    hit = 1'b0;
    idx = '0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if ((addr & mask[i*32 +: 32]) == base[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mio_bus_arb.sv
// CPU-side memory-mapped I/O bus controller with per-slave ready handshake and timeout.
// Optional error-capture status register enabled by defining MIO_ERR_CAPTURE_EN.
module mio_bus_arb
  import mio_pkg::*;
#(
  parameter int                     N_SLAVES    = 4,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE    = {LED_BASE, SEG7_BASE, VRAM_BASE, RAM_BASE},
  parameter logic [N_SLAVES*32-1:0] SLV_MASK    = {LED_MASK, SEG7_MASK, VRAM_MASK, RAM_MASK},
  parameter int                     TIMEOUT     = 16,
  parameter logic [31:0]            STATUS_ADDR = 32'hFFFF_FFF8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_wait,
  output logic [N_SLAVES-1:0]      s_sel,
  output logic                     s_we,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             timeout_hit;

  mio_addr_decode #(.N(N_SLAVES), .IDX_W(IDX_W)) u_decode (
    .addr (cpu_addr),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));

  // Ack and error are pure functions of the response states, so reset clears them.
  assign cpu_ack  = (state == ST_RESP) || (state == ST_ERR);
  assign cpu_err  = (state == ST_ERR);
  assign cpu_wait = cpu_req & ~cpu_ack;

`ifdef MIO_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
  logic        status_hit;

  // addr[2] selects between the two status words, so bits [2:0] are excluded.
  assign status_hit = (cpu_addr[31:3] == STATUS_ADDR[31:3]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      timer     <= '0;
      cpu_rdata <= '0;
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
`ifdef MIO_ERR_CAPTURE_EN
      err_addr  <= '0;
      err_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
`ifdef MIO_ERR_CAPTURE_EN
            if (status_hit) begin
              state     <= ST_RESP;
              cpu_rdata <= cpu_addr[2] ? err_addr : {err_cnt, 24'h0};
              if (cpu_we) begin
                err_addr <= '0;
                err_cnt  <= '0;
              end
            end else
`endif
            if (dec_hit) begin
              state   <= ST_ACCESS;
              idx     <= dec_idx;
              timer   <= '0;
              s_sel   <= N_SLAVES'(1) << dec_idx;
              s_we    <= cpu_we;
              s_addr  <= cpu_addr;
              s_wdata <= cpu_wdata;
            end else begin
              state     <= ST_ERR;
              cpu_rdata <= BUS_ERR_RDATA;
`ifdef MIO_ERR_CAPTURE_EN
              err_addr  <= cpu_addr;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
            end
          end
        end

        ST_ACCESS: begin
          // Ready is checked first so it wins over a simultaneous timeout.
          if (s_ready[idx]) begin
            state     <= ST_RESP;
            cpu_rdata <= s_rdata[idx*32 +: 32];
            s_sel     <= '0;
            s_we      <= 1'b0;
          end else if (timeout_hit) begin
            state     <= ST_ERR;
            cpu_rdata <= BUS_ERR_RDATA;
            s_sel     <= '0;
            s_we      <= 1'b0;
`ifdef MIO_ERR_CAPTURE_EN
            err_addr  <= s_addr;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arb.sv
// Directed self-checking bench for mio_bus_arb (default windows, TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge; outputs are checked after settling.
module tb_mio_bus_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ack;
  logic         cpu_err;
  logic [31:0]  cpu_rdata;
  logic         cpu_wait;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mio_bus_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .cpu_wait  (cpu_wait),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and let outputs settle before the next drive/check.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic release_req();
    cpu_req   = 1'b0;
    cpu_addr  = 32'hxxxx_xxxx;
    cpu_wdata = 32'hxxxx_xxxx;
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    s_rdata   = '0;
    s_ready   = '0;

    // ---- reset state
    step(); step();
    check("rst_ack",   {31'b0, cpu_ack}, 32'd0);
    check("rst_err",   {31'b0, cpu_err}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_sel",   {28'b0, s_sel}, 32'd0);
    check("rst_we",    {31'b0, s_we}, 32'd0);
    check("rst_saddr", s_addr, 32'd0);
    check("rst_swdat", s_wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: RAM read, zero wait states
    request(1'b0, 32'h0000_0010, 32'h0);
    s_rdata[31:0] = 32'h1234_5678;
    s_ready       = 4'b0001;
    #1;
    check("t1_c0_wait", {31'b0, cpu_wait}, 32'd1);
    check("t1_c0_sel",  {28'b0, s_sel}, 32'd0);
    step();
    check("t1_c1_sel",   {28'b0, s_sel}, 32'h1);
    check("t1_c1_we",    {31'b0, s_we}, 32'd0);
    check("t1_c1_saddr", s_addr, 32'h0000_0010);
    check("t1_c1_ack",   {31'b0, cpu_ack}, 32'd0);
    step();
    check("t1_c2_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t1_c2_err",   {31'b0, cpu_err}, 32'd0);
    check("t1_c2_rdata", cpu_rdata, 32'h1234_5678);
    check("t1_c2_sel",   {28'b0, s_sel}, 32'd0);
    check("t1_c2_wait",  {31'b0, cpu_wait}, 32'd0);
    release_req();
    s_ready = '0;
    step();
    check("t1_c3_ack",  {31'b0, cpu_ack}, 32'd0);
    check("t1_c3_hold", cpu_rdata, 32'h1234_5678);

    // ---- 2: LED write, 3 wait states; slave 0 ready is ignored
    request(1'b1, 32'hFFFF_FF00, 32'h0000_00A5);
    s_ready = 4'b0001;
    #1;
    check("t2_c0_wait", {31'b0, cpu_wait}, 32'd1);
    step();
    cpu_addr  = 32'h5555_5555;
    cpu_wdata = 32'h6666_6666;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("t2_c%0d_sel", c),   {28'b0, s_sel}, 32'h8);
      check($sformatf("t2_c%0d_we", c),    {31'b0, s_we}, 32'd1);
      check($sformatf("t2_c%0d_wdata", c), s_wdata, 32'h0000_00A5);
      check($sformatf("t2_c%0d_ack", c),   {31'b0, cpu_ack}, 32'd0);
      check($sformatf("t2_c%0d_wait", c),  {31'b0, cpu_wait}, 32'd1);
      step();
    end
    s_rdata[127:96] = 32'hDEAD_0003;
    s_ready         = 4'b1001;
    #1;
    check("t2_c4_we",    {31'b0, s_we}, 32'd1);
    check("t2_c4_wdata", s_wdata, 32'h0000_00A5);
    check("t2_c4_wait",  {31'b0, cpu_wait}, 32'd1);
    step();
    check("t2_c5_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t2_c5_err",   {31'b0, cpu_err}, 32'd0);
    check("t2_c5_rdata", cpu_rdata, 32'hDEAD_0003);
    check("t2_c5_we",    {31'b0, s_we}, 32'd0);
    release_req();
    s_ready = '0;
    step();

    // ---- 3: unmapped address
    request(1'b0, 32'h8000_0000, 32'h0);
    step();
    check("t3_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t3_err",   {31'b0, cpu_err}, 32'd1);
    check("t3_rdata", cpu_rdata, 32'd0);
    check("t3_sel",   {28'b0, s_sel}, 32'd0);
    release_req();
    step();
    check("t3_ack_clr", {31'b0, cpu_ack}, 32'd0);

    // ---- 4a: VRAM timeout after 16 ACCESS cycles
    request(1'b0, 32'h000C_0004, 32'h0);
    step();
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("t4a_c%0d_sel", c), {28'b0, s_sel}, 32'h2);
      check($sformatf("t4a_c%0d_ack", c), {31'b0, cpu_ack}, 32'd0);
      step();
    end
    check("t4a_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t4a_err",   {31'b0, cpu_err}, 32'd1);
    check("t4a_rdata", cpu_rdata, 32'd0);
    check("t4a_sel",   {28'b0, s_sel}, 32'd0);
    release_req();
    step();

    // ---- 4b: ready arrives in the same cycle as the timeout
    request(1'b0, 32'h000C_0004, 32'h0);
    step();
    for (int c = 1; c <= 15; c++) step();
    s_rdata[63:32] = 32'hCAFE_F00D;
    s_ready        = 4'b0010;
    #1;
    check("t4b_c16_sel", {28'b0, s_sel}, 32'h2);
    step();
    check("t4b_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t4b_err",   {31'b0, cpu_err}, 32'd0);
    check("t4b_rdata", cpu_rdata, 32'hCAFE_F00D);
    release_req();
    s_ready = '0;
    step();

    // ---- 5: reset during wait cycle 2 of a RAM read
    request(1'b0, 32'h0000_0020, 32'h0);
    step();
    step();
    check("t5_c2_sel", {28'b0, s_sel}, 32'h1);
    rst_n = 1'b0;
    step();
    check("t5_rst_sel",   {28'b0, s_sel}, 32'd0);
    check("t5_rst_ack",   {31'b0, cpu_ack}, 32'd0);
    check("t5_rst_saddr", s_addr, 32'd0);
    rst_n = 1'b1;
    release_req();
    step();
    check("t5_noack", {31'b0, cpu_ack}, 32'd0);
    request(1'b0, 32'h0000_0030, 32'h0);
    s_rdata[31:0] = 32'h0BAD_BEEF;
    s_ready       = 4'b0001;
    step();
    check("t5_new_sel", {28'b0, s_sel}, 32'h1);
    step();
    check("t5_new_ack",   {31'b0, cpu_ack}, 32'd1);
    check("t5_new_rdata", cpu_rdata, 32'h0BAD_BEEF);

    // ---- back-to-back: request held through the ack with a new 7SEG address
    request(1'b0, 32'hFFFF_FE04, 32'h0);
    s_rdata[95:64] = 32'h0000_0777;
    s_ready        = 4'b0100;
    step();
    check("b2b_idle_ack",  {31'b0, cpu_ack}, 32'd0);
    check("b2b_idle_wait", {31'b0, cpu_wait}, 32'd1);
    step();
    check("b2b_sel", {28'b0, s_sel}, 32'h4);
    step();
    check("b2b_ack",   {31'b0, cpu_ack}, 32'd1);
    check("b2b_rdata", cpu_rdata, 32'h0000_0777);
    release_req();
    s_ready = '0;
    step();

`ifdef MIO_ERR_CAPTURE_EN
    // ---- 6: error capture status register
    request(1'b0, 32'h8000_0000, 32'h0);
    step();
    release_req();
    step();
    request(1'b0, 32'h9000_0000, 32'h0);
    step();
    release_req();
    step();
    request(1'b0, 32'hFFFF_FFF8, 32'h0);
    step();
    check("t6_cnt_ack", {31'b0, cpu_ack}, 32'd1);
    check("t6_cnt",     cpu_rdata, 32'h0200_0000);
    check("t6_cnt_sel", {28'b0, s_sel}, 32'd0);
    release_req();
    step();
    request(1'b0, 32'hFFFF_FFFC, 32'h0);
    step();
    check("t6_addr", cpu_rdata, 32'h9000_0000);
    release_req();
    step();
    request(1'b1, 32'hFFFF_FFF8, 32'h0);
    step();
    check("t6_clr_ack", {31'b0, cpu_ack}, 32'd1);
    release_req();
    step();
    request(1'b0, 32'hFFFF_FFF8, 32'h0);
    step();
    check("t6_cnt_clr", cpu_rdata, 32'd0);
    release_req();
    step();
    request(1'b0, 32'hFFFF_FFFC, 32'h0);
    step();
    check("t6_addr_clr", cpu_rdata, 32'd0);
    release_req();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
